// File: rtl/sr_chk_pkg.sv
// Shared types and constants for the gated SR latch checker.
package sr_chk_pkg;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    SETTLE  = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_FORBID    = 2'd1;
  localparam logic [1:0] ERR_MISMATCH  = 2'd2;
  localparam logic [1:0] ERR_NOT_COMPL = 2'd3;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/sr_chk_sat_cnt.sv
// Up-counter with enable; SATURATE=1 holds at all-ones, SATURATE=0 wraps.
module sr_chk_sat_cnt #(
  parameter int W        = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && !(SATURATE && at_max)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sr_latch_checker.sv
// Cycle-level reference model and error monitor for a gated SR latch.
// Optional first-error trace capture is built when SR_CHK_TRACE_EN is defined.
module sr_latch_checker
  import sr_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  input  logic             c,
  input  logic             q,
  input  logic             q_n,
  output logic             exp_valid,
  output logic             exp_q,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_err_code,
  output logic [15:0]      first_err_cycle
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state, state_nxt;
  logic                exp_q_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
  logic [1:0]          err_p0;
  logic                forbid_p0, tgt_vld_p0, tgt_p0;

  // Stage p0: decode sampled latch inputs into a model target
  assign forbid_p0  = c & s & r;
  assign tgt_vld_p0 = c & (s ^ r);
  assign tgt_p0     = s;

  always_comb begin
    state_nxt      = state;
    exp_q_nxt      = exp_q;
    settle_cnt_nxt = settle_cnt;
    err_p0         = ERR_NONE;

    if (forbid_p0) begin
      err_p0         = ERR_FORBID;
      state_nxt      = UNKNOWN;
      exp_q_nxt      = 1'b0;
      settle_cnt_nxt = '0;
    end else begin
      if (state == CHECK) begin
        if (q != exp_q)     err_p0 = ERR_MISMATCH;
        else if (q == q_n)  err_p0 = ERR_NOT_COMPL;
      end

      if (tgt_vld_p0 && (state == UNKNOWN || tgt_p0 != exp_q)) begin
        state_nxt      = SETTLE;
        exp_q_nxt      = tgt_p0;
        settle_cnt_nxt = SETTLE_LOAD;
      end else if (state == SETTLE) begin
        if (settle_cnt == '0) state_nxt = CHECK;
        else                  settle_cnt_nxt = settle_cnt - 1'b1;
      end
    end
  end

  // Stage p1: registered model state and error report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNKNOWN;
      exp_q      <= 1'b0;
      settle_cnt <= '0;
      err_pulse  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_nxt;
      exp_q      <= exp_q_nxt;
      settle_cnt <= settle_cnt_nxt;
      err_pulse  <= (err_p0 != ERR_NONE);
      err_code   <= err_p0;
    end
  end

  assign exp_valid = (state != UNKNOWN);

  sr_chk_sat_cnt #(
    .W        (CNT_W),
    .SATURATE (1'b1)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (err_p0 != ERR_NONE),
    .cnt   (err_count)
  );

`ifdef SR_CHK_TRACE_EN
  logic [15:0] cyc_cnt;
  logic        captured;

  sr_chk_sat_cnt #(
    .W        (16),
    .SATURATE (1'b0)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .cnt   (cyc_cnt)
  );

  // cyc_cnt still holds the offending sample's index on the capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured        <= 1'b0;
      first_err_code  <= ERR_NONE;
      first_err_cycle <= '0;
    end else if (err_p0 != ERR_NONE && !captured) begin
      captured        <= 1'b1;
      first_err_code  <= err_p0;
      first_err_cycle <= cyc_cnt;
    end
  end
`else
  assign first_err_code  = ERR_NONE;
  assign first_err_cycle = '0;
`endif

endmodule

// File: tb/tb_sr_latch_checker.sv
// Directed, table-driven bench for sr_latch_checker (SETTLE_CYCLES=2, CNT_W=8).
module tb_sr_latch_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s = 1'b0, r = 1'b0, c = 1'b0, q = 1'b0, q_n = 1'b1;
  logic       exp_valid, exp_q, err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_count;
  logic [1:0] first_err_code;
  logic [15:0] first_err_cycle;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic c, s, r, q, qn;
    logic ev, eq, ep;
    logic [1:0] ec;
    logic [7:0] cnt;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  sr_latch_checker #(
    .SETTLE_CYCLES (2),
    .CNT_W         (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s               (s),
    .r               (r),
    .c               (c),
    .q               (q),
    .q_n             (q_n),
    .exp_valid       (exp_valid),
    .exp_q           (exp_q),
    .err_pulse       (err_pulse),
    .err_code        (err_code),
    .err_count       (err_count),
    .first_err_code  (first_err_code),
    .first_err_cycle (first_err_cycle)
  );

  function automatic vec_t mk(input logic c_i, s_i, r_i, q_i, qn_i,
                              input logic ev, eq, ep, input logic [1:0] ec,
                              input logic [7:0] cnt);
    vec_t v;
    v = '{c: c_i, s: s_i, r: r_i, q: q_i, qn: qn_i, ev: ev, eq: eq, ep: ep, ec: ec, cnt: cnt};
    return v;
  endfunction

  task automatic step(input logic c_i, s_i, r_i, q_i, qn_i);
    c = c_i; s = s_i; r = r_i; q = q_i; q_n = qn_i;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic ev, eq, ep,
                           input logic [1:0] ec, input logic [7:0] cnt);
    logic [12:0] act, req;
    act = {exp_valid, exp_q, err_pulse, err_code, err_count};
    req = {ev, eq, ep, ec, cnt};
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got valid=%b q=%b pulse=%b code=%0d count=%0d, want valid=%b q=%b pulse=%b code=%0d count=%0d",
               name, act[12], act[11], act[10], act[9:8], act[7:0],
               ev, eq, ep, ec, cnt);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  initial begin
    int  fcyc;
    logic [1:0] fcode;
    bit  seen;

    // c  s  r  q  qn | ev eq ep ec cnt
    for (int i = 0; i < 10; i++) vecs[i] = mk(0,0,0,0,1, 0,0,0,0,0);
    vecs[10] = mk(1,1,0,0,1, 1,1,0,0,0);   // set target -> SETTLE
    vecs[11] = mk(0,0,0,1,0, 1,1,0,0,0);
    vecs[12] = mk(0,0,0,1,0, 1,1,0,0,0);   // -> CHECK
    vecs[13] = mk(0,0,0,1,0, 1,1,0,0,0);
    vecs[14] = mk(0,0,0,1,0, 1,1,0,0,0);
    vecs[15] = mk(0,0,0,0,1, 1,1,1,2,1);   // mismatch x3
    vecs[16] = mk(0,0,0,0,1, 1,1,1,2,2);
    vecs[17] = mk(0,0,0,0,1, 1,1,1,2,3);
    vecs[18] = mk(0,0,0,1,0, 1,1,0,0,3);
    vecs[19] = mk(1,1,1,0,0, 0,0,1,1,4);   // forbidden beats not-compl
    vecs[20] = mk(1,0,0,0,0, 0,0,0,0,4);   // stays UNKNOWN
    vecs[21] = mk(1,1,0,1,0, 1,1,0,0,4);
    vecs[22] = mk(0,0,0,1,0, 1,1,0,0,4);
    vecs[23] = mk(0,0,0,1,0, 1,1,0,0,4);   // -> CHECK
    vecs[24] = mk(0,0,1,1,0, 1,1,0,0,4);   // c=0: hold
    vecs[25] = mk(0,0,1,0,1, 1,1,1,2,5);   // still CHECK, so compared
    vecs[26] = mk(1,0,1,1,0, 1,0,0,0,5);   // reset target -> SETTLE
    vecs[27] = mk(0,0,0,1,1, 1,0,0,0,5);   // masked
    vecs[28] = mk(0,0,0,1,1, 1,0,0,0,5);   // masked
    vecs[29] = mk(0,0,0,1,1, 1,0,1,2,6);   // mismatch beats not-compl
    vecs[30] = mk(0,0,0,0,0, 1,0,1,3,7);   // not-compl
    vecs[31] = mk(0,0,0,0,1, 1,0,0,0,7);
    vecs[32] = mk(1,0,1,1,0, 1,0,1,2,8);   // equal target: no re-settle
    vecs[33] = mk(0,0,0,1,0, 1,0,1,2,9);
    vecs[34] = mk(0,0,0,0,1, 1,0,0,0,9);

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0);
    check_val("reset_first_code", 32'(first_err_code), 0);
    check_val("reset_first_cycle", 32'(first_err_cycle), 0);
    rst_n = 1'b1;

    seen = 0; fcyc = 0; fcode = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].ep && !seen) begin
        seen = 1; fcyc = i; fcode = vecs[i].ec;
      end
      step(vecs[i].c, vecs[i].s, vecs[i].r, vecs[i].q, vecs[i].qn);
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eq, vecs[i].ep,
                vecs[i].ec, vecs[i].cnt);
    end

`ifdef SR_CHK_TRACE_EN
    check_val("first_err_code", 32'(first_err_code), 32'(fcode));
    check_val("first_err_cycle", 32'(first_err_cycle), 32'(fcyc));
`else
    check_val("first_err_code_tied", 32'(first_err_code), 0);
    check_val("first_err_cycle_tied", 32'(first_err_cycle), 0);
`endif

    // Continuous mismatch against exp_q=0 drives the counter into saturation
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 1, 0);
      if (i == 244) check_out("sat_254", 1, 0, 1, 2, 8'd254);
      if (i == 245) check_out("sat_255", 1, 0, 1, 2, 8'd255);
    end
    check_out("sat_hold", 1, 0, 1, 2, 8'd255);

    // Asynchronous reset in the middle of SETTLE
    step(1, 1, 0, 0, 1);
    check_out("pre_rst_settle", 1, 1, 0, 0, 8'd255);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 0);
    check_val("async_rst_first_code", 32'(first_err_code), 0);
    c = 0; s = 0; r = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 1, 0, 1);
    check_out("post_rst_unknown", 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1);
    check_out("forbid_1", 0, 0, 1, 1, 1);
    step(1, 1, 1, 0, 1);
    check_out("forbid_2", 0, 0, 1, 1, 2);
    step(0, 0, 0, 0, 1);
    check_out("forbid_end", 0, 0, 0, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
